// File: rtl/cam_capture_writer.sv
// cam_capture_writer: write-side producer for the 160x120 dual-port frame buffer.
// The module oversamples the camera bus (pclk, vsync, href, px_data) in the clk
// domain. It folds each RGB565 byte pair into one RGB332 byte and drives the
// buffer write port (addr_in, data_in, regwrite).
//
// Optional build macro: CAM_TEST_PATTERN_EN
//   defined   -> adds input test_pattern. When it is high, data_in carries the
//                low byte of the pixel counter, which gives a ramp image.
//   undefined -> data_in always carries the packed pixel.
//
// Pipeline, counted from the clk edge after a raw pclk rise:
//   edges 1..SYNC_STAGES : synchronizer
//   edge SYNC_STAGES+1   : the FSM accepts the byte (pixel completes on the low byte)
//   edge SYNC_STAGES+2   : the write stage drives regwrite, addr_in and data_in
module cam_capture_writer #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 8,
    parameter int FRAME_PIXELS = 19200,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pclk,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        px_data,
`ifdef CAM_TEST_PATTERN_EN
    input  logic              test_pattern,
`endif
    output logic [ADDR_W-1:0] addr_in,
    output logic [DATA_W-1:0] data_in,
    output logic              regwrite,
    output logic              frame_done,
    output logic              overflow
);

    // One synchronizer word per stage: {pclk, vsync, href, px_data}.
    localparam int SW = 11;

    // The counter saturates at this value. Reaching it means the frame is full.
    localparam logic [ADDR_W-1:0] FRAME_FULL = ADDR_W'(FRAME_PIXELS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BYTE_HI = 2'd1,
        BYTE_LO = 2'd2
    } state_t;

    logic [SW-1:0]     sync_reg [SYNC_STAGES];
    logic [SW-1:0]     sync_in;
    logic [SW-1:0]     sync_out;

    logic              pclk_s;
    logic              vsync_s;
    logic              href_s;
    logic [7:0]        data_s;

    logic              pclk_prev_reg;
    logic              vsync_prev_reg;
    logic              pclk_rise;
    logic              vs_rise;
    logic              byte_ok;

    state_t            state_reg;
    state_t            state_next;

    logic              take_hi;
    logic              take_lo;
    logic              frame_start;
    logic              frame_end;

    logic [7:0]        hi_reg;
    logic [7:0]        pix_packed;
    logic [7:0]        pix_reg;
    logic              pend_reg;

    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] wr_data;
    logic              regwrite_reg;
    logic              frame_done_reg;
    logic              overflow_reg;

    assign sync_in = {pclk, vsync, href, px_data};

    // The camera signals are asynchronous to clk, so every bit goes through the
    // same number of flops. This keeps the data aligned with its pclk edge.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First synchronizer stage samples the raw camera pins.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) sync_reg[0] <= '0;
                    else      sync_reg[0] <= sync_in;
                end
            end else begin : g_next
                // Later stages only shift the previous stage along.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) sync_reg[gi] <= '0;
                    else      sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sync_out = sync_reg[SYNC_STAGES-1];
    assign pclk_s   = sync_out[10];
    assign vsync_s  = sync_out[9];
    assign href_s   = sync_out[8];
    assign data_s   = sync_out[7:0];

    // Remember the previous synchronized pclk and vsync for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pclk_prev_reg  <= 1'b0;
            vsync_prev_reg <= 1'b0;
        end else begin
            pclk_prev_reg  <= pclk_s;
            vsync_prev_reg <= vsync_s;
        end
    end

    assign pclk_rise = pclk_s & ~pclk_prev_reg;
    assign vs_rise   = vsync_s & ~vsync_prev_reg;
    // A byte counts only inside a line and outside vertical blanking.
    assign byte_ok   = pclk_rise & href_s & ~vsync_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // FSM next state. A vsync rise restarts the frame from any state, and it
    // has priority over a byte that arrives in the same cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (vs_rise) state_next = BYTE_HI;
            end
            BYTE_HI: begin
                if (vs_rise)      state_next = BYTE_HI;
                else if (byte_ok) state_next = BYTE_LO;
            end
            BYTE_LO: begin
                // When href drops with only the high byte held, that byte is
                // abandoned and the FSM waits for a fresh pair.
                if (vs_rise)      state_next = BYTE_HI;
                else if (!href_s) state_next = BYTE_HI;
                else if (byte_ok) state_next = BYTE_HI;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: byte capture strobes and frame boundary events.
    always_comb begin
        take_hi     = 1'b0;
        take_lo     = 1'b0;
        frame_start = vs_rise;
        // The first vsync after reset only arms capture, so it reports no frame_done.
        frame_end   = vs_rise && (state_reg != IDLE);
        if (!vs_rise) begin
            take_hi = (state_reg == BYTE_HI) && byte_ok;
            take_lo = (state_reg == BYTE_LO) && byte_ok;
        end
    end

    // RGB565 {hi, lo} -> RGB332: R[4:2], G[5:3], B[4:3].
    assign pix_packed = {hi_reg[7:5], hi_reg[2:0], data_s[4:3]};

    // Byte capture. A completed pixel is parked in pix_reg for one cycle
    // before the write stage picks it up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_reg   <= 8'h00;
            pix_reg  <= 8'h00;
            pend_reg <= 1'b0;
        end else begin
            pend_reg <= take_lo;
            if (take_hi) hi_reg  <= data_s;
            if (take_lo) pix_reg <= pix_packed;
        end
    end

`ifdef CAM_TEST_PATTERN_EN
    assign wr_data = test_pattern ? DATA_W'(cnt_reg[7:0]) : DATA_W'(pix_reg);
`else
    assign wr_data = DATA_W'(pix_reg);
`endif

    // Write stage: this stage issues the buffer write, advances the pixel
    // counter and tracks overflow.
    // A frame restart has priority over a pending write. This keeps frame_done
    // and regwrite mutually exclusive, and the new frame always starts at address 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg        <= '0;
            addr_reg       <= '0;
            data_reg       <= '0;
            regwrite_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            regwrite_reg   <= 1'b0;
            frame_done_reg <= frame_end;
            if (frame_start) begin
                cnt_reg      <= '0;
                overflow_reg <= 1'b0;
            end else if (pend_reg) begin
                if (cnt_reg == FRAME_FULL) begin
                    // The frame is full. The pixel is dropped and addr_in keeps the last index.
                    overflow_reg <= 1'b1;
                end else begin
                    regwrite_reg <= 1'b1;
                    addr_reg     <= cnt_reg;
                    data_reg     <= wr_data;
                    cnt_reg      <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign addr_in    = addr_reg;
    assign data_in    = data_reg;
    assign regwrite   = regwrite_reg;
    assign frame_done = frame_done_reg;
    assign overflow   = overflow_reg;

endmodule
